fetch_queue: RTL and testbench
==============================

# fetch_queue

Decoupling FIFO between the instruction-fetch stage and decode. It accepts one fetched instruction and its PC per cycle from IF and presents them in order to decode with a valid/ready handshake. Stalls on either side are absorbed by up to `DEPTH` entries. A single-cycle flush discards all contents on redirect (branch mispredict or exception).

## Interface
Parameters:
- `DEPTH`, default 4: number of entries; power of two, ≥ 2.
- `PTR_W`, default `$clog2(DEPTH)`: pointer width; derived, not overridden.

Ports:
- `clk_i`, input, 1: single clock, rising edge.
- `reset_i`, input, 1: asynchronous, active-high reset.
- `flush_i`, input, 1: discard all entries at the next edge.
- `push_valid_i`, input, 1: IF offers an instruction this cycle.
- `push_ready_o`, output, 1: queue can accept an instruction; equals `!full`.
- `push_pc_i`, input, `ADDR_LEN`: PC of the offered instruction.
- `push_inst_i`, input, `INSN_LEN`: offered instruction word.
- `pop_valid_o`, output, 1: head entry valid toward decode.
- `pop_ready_i`, input, 1: decode consumes the head this cycle.
- `pop_pc_o`, output, `ADDR_LEN`: PC of the head entry.
- `pop_inst_o`, output, `INSN_LEN`: instruction word of the head entry.
- `count_o`, output, `PTR_W+1`: current occupancy, 0..`DEPTH`.

## Operation
- State: storage array of `{pc, inst}` pairs, read pointer `rd_ptr`, write pointer `wr_ptr` (each `PTR_W` bits, wrapping modulo `DEPTH`), and occupancy register `count` (`PTR_W+1` bits).
- Push fires when `push_valid_i && push_ready_o`. On a push, the entry is written at `wr_ptr` and `wr_ptr` increments.
- Pop fires when `pop_valid_o && pop_ready_i`. On a pop, `rd_ptr` increments.
- `count` updates each edge as `count + push - pop`. Simultaneous push and pop leaves `count` unchanged.
- `full = (count == DEPTH)`. `empty = (count == 0)`.
- When full, `push_ready_o` is 0 even if a pop fires in the same cycle. The queue never passes through when full.
- When not empty: `pop_valid_o = 1`, and `pop_pc_o`/`pop_inst_o` are driven from the entry at `rd_ptr`.
- When empty (bypass off): `pop_valid_o = 0`, and `pop_pc_o` and `pop_inst_o` are forced to 0.
- `flush_i` dominates. At the edge: `rd_ptr = wr_ptr = count = 0`, and any push or pop in that cycle is ignored.
  - `push_ready_o` and `pop_valid_o` are unaffected combinationally during the flush cycle.
  - Upstream must treat that cycle's push as lost.
- Storage contents are not reset; only the pointers and `count` are.

## Timing
- Reset (async assert) values:
  - `count_o = 0`, `pop_valid_o = 0`, `push_ready_o = 1`.
  - `pop_pc_o = 0`, `pop_inst_o = 0`.
- Reset asserted mid-operation drops all entries immediately, with no edge required.
- Latency with bypass off: push at edge N makes the entry visible on `pop_*` in cycle N+1. One cycle minimum.
- Throughput: one push and one pop per cycle sustained when `0 < count < DEPTH`.
- Outputs are combinational from registered state only. `push_ready_o` has no path from `pop_ready_i`.
- Pointer wrap: after pointer value `DEPTH-1`, the next value is 0. There is no extra wrap bit; `count` disambiguates full from empty.

## Configuration
- Macro: `FETCH_QUEUE_BYPASS_EN`.
- Defined:
  - When empty, `pop_valid_o = push_valid_i`, and `pop_pc_o`/`pop_inst_o` equal `push_pc_i`/`push_inst_i` combinationally.
  - If `pop_ready_i` is also high, the instruction passes through, nothing is written, and `count` stays 0.
  - Bypass is suppressed during `flush_i`.
  - Zero-cycle latency when empty.
- Undefined: behaviour as in Operation, with a minimum one-cycle latency and no combinational input-to-output path.

## Structure
- Shared constants in `consts/Consts.vh`:
  - `ADDR_LEN` and `INSN_LEN` (existing).
  - New `FETCH_QUEUE_DEPTH` (default 4), used by the core top to set `DEPTH`.
- Sub-module `fetch_queue_ram`:
  - `DEPTH` × (`ADDR_LEN` + `INSN_LEN`) register array.
  - One synchronous write port and one asynchronous read port, no reset.
  - Pointer, count, flush and handshake logic stay in `fetch_queue`.

## Test plan
- Reset then idle: `count_o = 0`, `pop_valid_o = 0`, `pop_inst_o = 0`, `push_ready_o = 1`.
- Fill with `pop_ready_i = 0`: push PCs `0x1000`, `0x1004`, `0x1008`, `0x100C`.
  - Expect `count_o = 4` and `push_ready_o = 0`.
  - A fifth push of `0x1010` is not accepted.
  - Draining then yields `0x1000`…`0x100C` in order.
- Wrap-around: 10 back-to-back push and pop pairs (PC `0x2000` + 4k) with DEPTH 4.
  - Expect output order preserved and `count_o` steady at 1 after the first cycle.
- Full with simultaneous pop: at `count = 4`, assert `pop_ready_i` and `push_valid_i`.
  - Expect the pop accepted, the push refused, and `count_o = 3`.
- Flush with push and pop in the same cycle at `count = 3`.
  - Next cycle: `count_o = 0`, `pop_valid_o = 0`.
  - The pushed instruction never appears.
- Bypass (macro defined): empty queue, push `0x3000`/`0x00000013` with `pop_ready_i = 1`.
  - `pop_valid_o = 1` and `pop_inst_o = 0x00000013` in the same cycle.
  - `count_o` stays 0.
  - With the macro undefined, the same stimulus gives `pop_valid_o = 0` in that cycle and 1 in the next.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared widths and entry type for the fetch queue between IF and decode.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_queue_pkg;

    localparam int ADDR_LEN          = 32;
    localparam int INSN_LEN          = 32;
    localparam int FETCH_QUEUE_DEPTH = 4;

    // One queue slot: the fetched instruction together with its PC.
    typedef struct packed {
        logic [ADDR_LEN-1:0] pc;
        logic [INSN_LEN-1:0] inst;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// Storage array for fetch_queue: DEPTH x {pc, inst}, no reset on contents.
// Latency: write lands at the clock edge; read is combinational from raddr_i.
// Backpressure: none; the parent decides when writes are allowed.
//
// Ports: clk_i, we_i/waddr_i/wdata_i (sync write), raddr_i/rdata_o (async read).
module fetch_queue_ram
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FETCH_QUEUE_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  fq_entry_t        wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output fq_entry_t        rdata_o
);

    fq_entry_t mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// In-order decoupling FIFO from instruction fetch to decode, with single-cycle flush.
// Latency: 1 cycle push-to-pop; 0 cycles when empty if FETCH_QUEUE_BYPASS_EN is defined.
// Backpressure: push_ready_o = !full (never depends on pop_ready_i); decode stalls via pop_ready_i.
//
// Ports: clk_i, reset_i (async, active-high), flush_i; push_valid_i/push_ready_o/push_pc_i/push_inst_i
// from IF; pop_valid_o/pop_ready_i/pop_pc_o/pop_inst_o to decode; count_o occupancy 0..DEPTH.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (empty-queue pass-through).
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FETCH_QUEUE_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                flush_i,
    input  logic                push_valid_i,
    output logic                push_ready_o,
    input  logic [ADDR_LEN-1:0] push_pc_i,
    input  logic [INSN_LEN-1:0] push_inst_i,
    output logic                pop_valid_o,
    input  logic                pop_ready_i,
    output logic [ADDR_LEN-1:0] pop_pc_o,
    output logic [INSN_LEN-1:0] pop_inst_o,
    output logic [PTR_W:0]      count_o
);

    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push_fire;
    logic             pop_fire;
    fq_entry_t        wr_entry;
    fq_entry_t        rd_entry;

    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign wr_entry = '{pc: push_pc_i, inst: push_inst_i};

    // Pointers wrap naturally because DEPTH is a power of two; count tells full from empty.
    fetch_queue_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (push_fire && !flush_i),
        .waddr_i (wr_ptr),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr),
        .rdata_o (rd_entry)
    );

    // No pass-through when full: a same-cycle pop does not reopen the push side.
    assign push_ready_o = !full;
    assign count_o      = count;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass_vld;

    // An empty queue forwards the offered instruction straight to decode, except during flush.
    assign bypass_vld  = empty && push_valid_i && !flush_i;
    assign pop_valid_o = !empty || bypass_vld;
    // Only stored entries advance rd_ptr; a consumed bypass is never written.
    assign pop_fire    = !empty && pop_ready_i;
    assign push_fire   = push_valid_i && push_ready_o && !(bypass_vld && pop_ready_i);

    always_comb begin
        pop_pc_o   = '0;
        pop_inst_o = '0;
        if (!empty) begin
            pop_pc_o   = rd_entry.pc;
            pop_inst_o = rd_entry.inst;
        end else if (bypass_vld) begin
            pop_pc_o   = push_pc_i;
            pop_inst_o = push_inst_i;
        end
    end
`else
    assign pop_valid_o = !empty;
    assign pop_fire    = pop_valid_o && pop_ready_i;
    assign push_fire   = push_valid_i && push_ready_o;

    // Stale storage is masked so decode sees zeros while the queue is empty.
    always_comb begin
        pop_pc_o   = '0;
        pop_inst_o = '0;
        if (!empty) begin
            pop_pc_o   = rd_entry.pc;
            pop_inst_o = rd_entry.inst;
        end
    end
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            // Flush wins over any handshake in the same cycle.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_fire, pop_fire})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: vector table plus scoreboard, wrap and async-reset sequences.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: pop_ready_i and push_valid_i come from the vectors; the model tracks acceptance.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);

    logic                clk_i;
    logic                reset_i;
    logic                flush_i;
    logic                push_valid_i;
    logic                push_ready_o;
    logic [ADDR_LEN-1:0] push_pc_i;
    logic [INSN_LEN-1:0] push_inst_i;
    logic                pop_valid_o;
    logic                pop_ready_i;
    logic [ADDR_LEN-1:0] pop_pc_o;
    logic [INSN_LEN-1:0] pop_inst_o;
    logic [PTR_W:0]      count_o;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .flush_i      (flush_i),
        .push_valid_i (push_valid_i),
        .push_ready_o (push_ready_o),
        .push_pc_i    (push_pc_i),
        .push_inst_i  (push_inst_i),
        .pop_valid_o  (pop_valid_o),
        .pop_ready_i  (pop_ready_i),
        .pop_pc_o     (pop_pc_o),
        .pop_inst_o   (pop_inst_o),
        .count_o      (count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic                pv;
        logic [ADDR_LEN-1:0] pc;
        logic [INSN_LEN-1:0] inst;
        logic                pr;
        logic                fl;
        int                  cnt;   // expected count_o before the edge
        logic                prdy;  // expected push_ready_o
        logic                pvld;  // expected pop_valid_o with bypass off
    } vec_t;

    int        n_cmp = 0;
    int        n_err = 0;
    fq_entry_t sb[$];
    vec_t      tbl[$];

    function automatic logic [INSN_LEN-1:0] inst_of(input logic [ADDR_LEN-1:0] pc);
        return ~pc ^ 32'h5A00_0000;
    endfunction

    function automatic vec_t mk(input logic pv, input logic [ADDR_LEN-1:0] pc, input logic pr,
                                input logic fl, input int cnt, input logic prdy, input logic pvld);
        vec_t v;
        v.pv   = pv;
        v.pc   = pc;
        v.inst = inst_of(pc);
        v.pr   = pr;
        v.fl   = fl;
        v.cnt  = cnt;
        v.prdy = prdy;
        v.pvld = pvld;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Applies one cycle of stimulus, compares outputs, then updates the scoreboard.
    task automatic drive_cycle(input vec_t v, input string tag);
        fq_entry_t exp_e;
        logic      exp_vld;
        logic      accept;
        logic      pass;
        push_valid_i = v.pv;
        push_pc_i    = v.pc;
        push_inst_i  = v.inst;
        pop_ready_i  = v.pr;
        flush_i      = v.fl;
        @(negedge clk_i);
        exp_vld = v.pvld;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (v.cnt == 0 && v.pv && !v.fl) exp_vld = 1'b1;
`endif
        check({tag, " count"}, 64'(count_o), 64'(v.cnt));
        check({tag, " push_ready"}, 64'(push_ready_o), 64'(v.prdy));
        check({tag, " pop_valid"}, 64'(pop_valid_o), 64'(exp_vld));
        if (exp_vld) begin
            if (sb.size() > 0) exp_e = sb[0];
            else               exp_e = '{pc: v.pc, inst: v.inst};
            check({tag, " pop_pc"}, 64'(pop_pc_o), 64'(exp_e.pc));
            check({tag, " pop_inst"}, 64'(pop_inst_o), 64'(exp_e.inst));
        end else begin
            check({tag, " pop_pc zero"}, 64'(pop_pc_o), 64'd0);
            check({tag, " pop_inst zero"}, 64'(pop_inst_o), 64'd0);
        end
        accept = v.pv && (sb.size() < DEPTH);
        pass   = 1'b0;
        if (v.fl) begin
            sb.delete();
        end else begin
            if (exp_vld && v.pr) begin
                if (sb.size() > 0) exp_e = sb.pop_front();
                else               pass  = 1'b1;
            end
            if (accept && !pass) sb.push_back('{pc: v.pc, inst: v.inst});
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        vec_t v;
        push_valid_i = 1'b0;
        push_pc_i    = '0;
        push_inst_i  = '0;
        pop_ready_i  = 1'b0;
        flush_i      = 1'b0;
        reset_i      = 1'b0;
        #1 reset_i   = 1'b1;
        #2;
        check("reset count", 64'(count_o), 64'd0);
        check("reset pop_valid", 64'(pop_valid_o), 64'd0);
        check("reset push_ready", 64'(push_ready_o), 64'd1);
        check("reset pop_pc", 64'(pop_pc_o), 64'd0);
        check("reset pop_inst", 64'(pop_inst_o), 64'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) reset_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Idle, fill to full, refused fifth push, pop while full, drain.
        tbl.push_back(mk(0, 32'h0,    0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 32'h1000, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 32'h1004, 0, 0, 1, 1, 1));
        tbl.push_back(mk(1, 32'h1008, 0, 0, 2, 1, 1));
        tbl.push_back(mk(1, 32'h100C, 0, 0, 3, 1, 1));
        tbl.push_back(mk(1, 32'h1010, 0, 0, 4, 0, 1));
        tbl.push_back(mk(1, 32'h1010, 1, 0, 4, 0, 1));
        tbl.push_back(mk(0, 32'h0,    0, 0, 3, 1, 1));
        tbl.push_back(mk(0, 32'h0,    1, 0, 3, 1, 1));
        tbl.push_back(mk(0, 32'h0,    1, 0, 2, 1, 1));
        tbl.push_back(mk(0, 32'h0,    1, 0, 1, 1, 1));
        tbl.push_back(mk(0, 32'h0,    0, 0, 0, 1, 0));
        // Flush with push and pop in the same cycle at count 3; 0x400C must never appear.
        tbl.push_back(mk(1, 32'h4000, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 32'h4004, 0, 0, 1, 1, 1));
        tbl.push_back(mk(1, 32'h4008, 0, 0, 2, 1, 1));
        tbl.push_back(mk(1, 32'h400C, 1, 1, 3, 1, 1));
        tbl.push_back(mk(0, 32'h0,    1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 32'h5000, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 32'h0,    1, 0, 1, 1, 1));
        tbl.push_back(mk(0, 32'h0,    0, 0, 0, 1, 0));
        // Push with pop_ready into an empty queue.
        v = mk(1, 32'h3000, 1, 0, 0, 1, 0);
        v.inst = 32'h0000_0013;
        tbl.push_back(v);
`ifdef FETCH_QUEUE_BYPASS_EN
        tbl.push_back(mk(0, 32'h0,    1, 0, 0, 1, 0));
`else
        tbl.push_back(mk(0, 32'h0,    1, 0, 1, 1, 1));
        tbl.push_back(mk(0, 32'h0,    0, 0, 0, 1, 0));
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            drive_cycle(tbl[i], $sformatf("v%0d", i));
        end

        // Ten back-to-back push/pop pairs wrap both pointers more than twice.
        for (int k = 0; k < 10; k++) begin
`ifdef FETCH_QUEUE_BYPASS_EN
            v = mk(1, 32'h2000 + 32'(4 * k), 1, 0, 0, 1, 0);
`else
            v = mk(1, 32'h2000 + 32'(4 * k), 1, 0, (k == 0) ? 0 : 1, 1, (k == 0) ? 1'b0 : 1'b1);
`endif
            drive_cycle(v, $sformatf("wrap%0d", k));
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        drive_cycle(mk(0, 32'h0, 1, 0, 0, 1, 0), "wrap drain");
`else
        drive_cycle(mk(0, 32'h0, 1, 0, 1, 1, 1), "wrap drain");
`endif
        drive_cycle(mk(0, 32'h0, 0, 0, 0, 1, 0), "wrap empty");

        // Reset asserted mid-cycle drops entries without waiting for an edge.
        drive_cycle(mk(1, 32'h6000, 0, 0, 0, 1, 0), "pre-rst a");
        drive_cycle(mk(1, 32'h6004, 0, 0, 1, 1, 1), "pre-rst b");
        push_valid_i = 1'b0;
        pop_ready_i  = 1'b0;
        #2;
        check("pre-reset count", 64'(count_o), 64'd2);
        reset_i = 1'b1;
        #1;
        check("async reset count", 64'(count_o), 64'd0);
        check("async reset pop_valid", 64'(pop_valid_o), 64'd0);
        check("async reset push_ready", 64'(push_ready_o), 64'd1);
        check("async reset pop_pc", 64'(pop_pc_o), 64'd0);
        sb.delete();
        @(negedge clk_i) reset_i = 1'b0;
        @(posedge clk_i);
        #1;
        drive_cycle(mk(0, 32'h0, 1, 0, 0, 1, 0), "post-rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
